// File: rtl/nco_quadrature.sv
// nco_quadrature: phase-accumulator NCO with a quarter-wave sine table and
// quadrant folding. Three registered stages (address, table lookup, sign)
// produce signed sin/cos samples with a matching valid strobe.
module nco_quadrature #(
  parameter int PHASE_WIDTH = 32,
  parameter int LUT_DEPTH   = 8,
  parameter int DATA_WIDTH  = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         freq_load,
  input  logic [PHASE_WIDTH-1:0]       freq_word,
  input  logic                         phase_clear,
  input  logic [LUT_DEPTH-1:0]         phase_offset,
  output logic signed [DATA_WIDTH-1:0] sin_out,
  output logic signed [DATA_WIDTH-1:0] cos_out,
  output logic                         out_valid
);

  // Quarter-wave geometry: N points per quadrant, table holds N+1 entries.
  localparam int N  = 2 ** (LUT_DEPTH - 2);
  localparam int IW = LUT_DEPTH - 2;   // in-quadrant index bits
  localparam int KW = LUT_DEPTH - 1;   // table index bits (0..N inclusive)
  localparam int MW = DATA_WIDTH - 1;  // magnitude bits (0..A)

  // Q[k] = floor(A*sin(pi*k/(2N))), evaluated at elaboration with a Taylor
  // series; the tiny bias keeps sin(pi/2) from rounding just below A.
  function automatic logic [MW-1:0] quarter_sample(input int k);
    real pi_r;
    real x;
    real term;
    real sum;
    real amp;
    pi_r = 3.14159265358979323846;
    x    = pi_r * real'(k) / real'(2 * N);
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    amp = real'((2 ** (DATA_WIDTH - 1)) - 1);
    return MW'($rtoi(amp * sum + 1.0e-9));
  endfunction

  // Map a full-wave address to {negate, quarter-table index}.
  function automatic logic [KW:0] fold_index(input logic [LUT_DEPTH-1:0] a);
    logic [1:0]    quad;
    logic [KW-1:0] idx;
    logic          neg;
    quad = a[LUT_DEPTH-1 -: 2];
    case (quad)
      2'd0: begin idx = {1'b0, a[IW-1:0]};          neg = 1'b0; end
      2'd1: begin idx = KW'(N) - {1'b0, a[IW-1:0]}; neg = 1'b0; end
      2'd2: begin idx = {1'b0, a[IW-1:0]};          neg = 1'b1; end
      2'd3: begin idx = KW'(N) - {1'b0, a[IW-1:0]}; neg = 1'b1; end
      default: begin idx = {KW{1'b0}};              neg = 1'b0; end
    endcase
    return {neg, idx};
  endfunction

  // Two's-complement sign application; a zero magnitude stays zero.
  function automatic logic [DATA_WIDTH-1:0] apply_sign(input logic [MW-1:0] mag,
                                                       input logic          neg);
    logic [DATA_WIDTH-1:0] ext;
    ext = {1'b0, mag};
    return neg ? (-ext) : ext;
  endfunction

  // Quarter-wave table as constant wires.
  logic [MW-1:0] qtab_s [0:N];
  for (genvar k = 0; k <= N; k++) begin : g_qtab
    localparam logic [MW-1:0] QV = quarter_sample(k);
    assign qtab_s[k] = QV;
  end

  // State and next-state.
  logic [PHASE_WIDTH-1:0] inc_q, inc_d;
  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [LUT_DEPTH-1:0]   addr_s_q, addr_s_d, addr_c_q, addr_c_d;
  logic                   v1_q, v2_q, v3_q;
  logic [MW-1:0]          mag_s_q, mag_s_d, mag_c_q, mag_c_d;
  logic                   neg_s_q, neg_s_d, neg_c_q, neg_c_d;
  logic [DATA_WIDTH-1:0]  sin_q, sin_d, cos_q, cos_d;
  logic [KW:0]            fold_s, fold_c;

  // Increment register and accumulator next state (clear beats enable).
  always_comb begin
    inc_d = inc_q;
    acc_d = acc_q;
    if (freq_load) begin
      inc_d = freq_word;
    end else begin
      inc_d = inc_q;
    end
    if (phase_clear) begin
      acc_d = {PHASE_WIDTH{1'b0}};
    end else if (enable) begin
      acc_d = acc_q + inc_q;
    end else begin
      acc_d = acc_q;
    end
  end

  // Stage 1: truncate phase, add offset, derive the cosine address.
  always_comb begin
    addr_s_d = acc_q[PHASE_WIDTH-1 -: LUT_DEPTH] + phase_offset;
    addr_c_d = addr_s_d + LUT_DEPTH'(N);
  end

  // Stage 2: quadrant fold and table lookup for both channels.
  always_comb begin
    fold_s  = fold_index(addr_s_q);
    fold_c  = fold_index(addr_c_q);
    mag_s_d = qtab_s[fold_s[KW-1:0]];
    neg_s_d = fold_s[KW];
    mag_c_d = qtab_s[fold_c[KW-1:0]];
    neg_c_d = fold_c[KW];
  end

  // Stage 3: apply sign; outputs only change when a valid sample arrives.
  always_comb begin
    sin_d = sin_q;
    cos_d = cos_q;
    if (v2_q) begin
      sin_d = apply_sign(mag_s_q, neg_s_q);
      cos_d = apply_sign(mag_c_q, neg_c_q);
    end else begin
      sin_d = sin_q;
      cos_d = cos_q;
    end
  end

  // All state registers; asynchronous reset clears everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q    <= {PHASE_WIDTH{1'b0}};
      acc_q    <= {PHASE_WIDTH{1'b0}};
      addr_s_q <= {LUT_DEPTH{1'b0}};
      addr_c_q <= {LUT_DEPTH{1'b0}};
      v1_q     <= 1'b0;
      mag_s_q  <= {MW{1'b0}};
      mag_c_q  <= {MW{1'b0}};
      neg_s_q  <= 1'b0;
      neg_c_q  <= 1'b0;
      v2_q     <= 1'b0;
      sin_q    <= {DATA_WIDTH{1'b0}};
      cos_q    <= {DATA_WIDTH{1'b0}};
      v3_q     <= 1'b0;
    end else begin
      inc_q    <= inc_d;
      acc_q    <= acc_d;
      addr_s_q <= addr_s_d;
      addr_c_q <= addr_c_d;
      v1_q     <= enable;
      mag_s_q  <= mag_s_d;
      mag_c_q  <= mag_c_d;
      neg_s_q  <= neg_s_d;
      neg_c_q  <= neg_c_d;
      v2_q     <= v1_q;
      sin_q    <= sin_d;
      cos_q    <= cos_d;
      v3_q     <= v2_q;
    end
  end

  assign sin_out   = sin_q;
  assign cos_out   = cos_q;
  assign out_valid = v3_q;

endmodule

// File: tb/tb_nco_quadrature.sv
// Directed bench for nco_quadrature: default instance (7-bit, 256 points)
// plus a 12-bit / 1024-point instance for the wider-table case.
module tb_nco_quadrature;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable, freq_load, phase_clear;
  logic [31:0]        freq_word;
  logic [7:0]         phase_offset;
  logic signed [6:0]  sin_out, cos_out;
  logic               out_valid;

  logic               enable2, freq_load2, phase_clear2;
  logic [31:0]        freq_word2;
  logic [9:0]         phase_offset2;
  logic signed [11:0] sin2, cos2;
  logic               valid2;

  int tests = 0;
  int fails = 0;
  int cap_sin [1024];
  int cap_cos [1024];

  typedef struct {
    int k;
    int s;
    int c;
  } vec_t;
  vec_t vecs [8];

  nco_quadrature dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .freq_load(freq_load),
    .freq_word(freq_word), .phase_clear(phase_clear), .phase_offset(phase_offset),
    .sin_out(sin_out), .cos_out(cos_out), .out_valid(out_valid)
  );

  nco_quadrature #(.PHASE_WIDTH(32), .LUT_DEPTH(10), .DATA_WIDTH(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable2), .freq_load(freq_load2),
    .freq_word(freq_word2), .phase_clear(phase_clear2), .phase_offset(phase_offset2),
    .sin_out(sin2), .cos_out(cos2), .out_valid(valid2)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ideal sample rounded toward zero (small bias absorbs libm rounding).
  function automatic int model(input int amp, input int k, input int pts, input bit is_cos);
    real x;
    real v;
    x = 2.0 * 3.14159265358979323846 * real'(k) / real'(pts);
    v = real'(amp) * (is_cos ? $cos(x) : $sin(x));
    v = v + ((v >= 0.0) ? 1.0e-9 : -1.0e-9);
    return $rtoi(v);
  endfunction

  // Enable n consecutive cycles, capture the n samples, check valid timing.
  task automatic collect(input bit sel, input int n);
    for (int c = 0; c < n + 3; c++) begin
      if (sel) enable2 = (c < n);
      else     enable  = (c < n);
      check($sformatf("valid[%0d]", c), sel ? int'(valid2) : int'(out_valid), (c >= 3) ? 1 : 0);
      if (c >= 3) begin
        cap_sin[c-3] = sel ? int'(sin2) : int'(sin_out);
        cap_cos[c-3] = sel ? int'(cos2) : int'(cos_out);
      end
      step();
    end
    enable  = 1'b0;
    enable2 = 1'b0;
    check("valid_after", sel ? int'(valid2) : int'(out_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; freq_load = 1'b0; phase_clear = 1'b0;
    freq_word = 32'd0; phase_offset = 8'd0;
    enable2 = 1'b0; freq_load2 = 1'b0; phase_clear2 = 1'b0;
    freq_word2 = 32'd0; phase_offset2 = 10'd0;

    vecs[0] = '{k: 0,   s: 0,   c: 63};
    vecs[1] = '{k: 1,   s: 1,   c: 62};
    vecs[2] = '{k: 2,   s: 3,   c: 62};
    vecs[3] = '{k: 3,   s: 4,   c: 62};
    vecs[4] = '{k: 64,  s: 63,  c: 0};
    vecs[5] = '{k: 128, s: 0,   c: -63};
    vecs[6] = '{k: 129, s: -1,  c: -62};
    vecs[7] = '{k: 192, s: -63, c: 0};

    // Reset state
    #12;
    check("rst_sin", int'(sin_out), 0);
    check("rst_cos", int'(cos_out), 0);
    check("rst_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Full-period sweep at one address step per sample
    freq_word = 32'h0100_0000; freq_load = 1'b1;
    step();
    freq_load = 1'b0;
    collect(1'b0, 256);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("vec_sin[%0d]", vecs[i].k), cap_sin[vecs[i].k], vecs[i].s);
      check($sformatf("vec_cos[%0d]", vecs[i].k), cap_cos[vecs[i].k], vecs[i].c);
    end
    for (int k = 0; k < 256; k++) begin
      check($sformatf("sweep_sin[%0d]", k), cap_sin[k], model(63, k, 256, 1'b0));
      check($sformatf("sweep_cos[%0d]", k), cap_cos[k], model(63, k, 256, 1'b1));
    end

    // Half-period increment: accumulator wraps every two samples
    phase_clear = 1'b1; freq_load = 1'b1; freq_word = 32'h8000_0000;
    step();
    phase_clear = 1'b0; freq_load = 1'b0;
    collect(1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("half_sin[%0d]", i), cap_sin[i], 0);
      check($sformatf("half_cos[%0d]", i), cap_cos[i], (i % 2 == 0) ? 63 : -63);
    end

    // Quarter-wave offset with zero increment, then gapped enables
    phase_clear = 1'b1; freq_load = 1'b1; freq_word = 32'd0;
    step();
    phase_clear = 1'b0; freq_load = 1'b0; phase_offset = 8'd64;
    collect(1'b0, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("off_sin[%0d]", i), cap_sin[i], 63);
      check($sformatf("off_cos[%0d]", i), cap_cos[i], 0);
    end
    for (int c = 0; c < 6; c++) begin
      enable = (c == 0 || c == 2);
      check($sformatf("gap_valid[%0d]", c), int'(out_valid), (c == 3 || c == 5) ? 1 : 0);
      if (c == 3 || c == 5) check($sformatf("gap_sin[%0d]", c), int'(sin_out), 63);
      step();
    end
    enable = 1'b0; phase_offset = 8'd0;

    // Asynchronous reset in the middle of a stream
    phase_clear = 1'b1; freq_load = 1'b1; freq_word = 32'h0100_0000;
    step();
    phase_clear = 1'b0; freq_load = 1'b0; enable = 1'b1;
    repeat (10) step();
    check("pre_rst_sin", int'(sin_out), 10);
    check("pre_rst_cos", int'(cos_out), 62);
    check("pre_rst_valid", int'(out_valid), 1);
    #3;
    rst_n = 1'b0; enable = 1'b0;
    #1;
    check("async_sin", int'(sin_out), 0);
    check("async_cos", int'(cos_out), 0);
    check("async_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    freq_load = 1'b1;
    step();
    freq_load = 1'b0;
    check("post_rst_valid", int'(out_valid), 0);
    collect(1'b0, 3);
    check("restart_sin0", cap_sin[0], 0);
    check("restart_sin1", cap_sin[1], 1);
    check("restart_sin2", cap_sin[2], 3);
    check("restart_cos0", cap_cos[0], 63);

    // Wide instance: 12-bit output, 1024-point wave
    freq_word2 = 32'h0040_0000; freq_load2 = 1'b1;
    step();
    freq_load2 = 1'b0;
    collect(1'b1, 1024);
    check("w_sin0", cap_sin[0], 0);
    check("w_cos0", cap_cos[0], 2047);
    check("w_peak_pos", cap_sin[256], 2047);
    check("w_peak_neg", cap_sin[768], -2047);
    check("w_cos256", cap_cos[256], 0);
    check("w_cos512", cap_cos[512], -2047);
    for (int j = 1; j <= 8; j++) begin
      check($sformatf("w_sym_pos[%0d]", j), cap_sin[256+j], cap_sin[256-j]);
      check($sformatf("w_sym_neg[%0d]", j), cap_sin[768+j], cap_sin[768-j]);
    end
    for (int k = 0; k < 1024; k += 37) begin
      check($sformatf("w_sin[%0d]", k), cap_sin[k], model(2047, k, 1024, 1'b0));
      check($sformatf("w_cos[%0d]", k), cap_cos[k], model(2047, k, 1024, 1'b1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
